// File: rtl/reg_bank_32x32_pkg.sv
// -----------------------------------------------------------------------------
// regbank_pkg
// Shared constants and types for the 32 x 32-bit architectural register bank.
//
// Contents:
//   DATA_WIDTH, ADDR_WIDTH, REG_COUNT : bank geometry
//   SP_INDEX, SP_INIT                 : stack-pointer register and its reset value
//   ZERO_INDEX                        : hardwired-zero register index
//   mode_e                            : per-edge operating mode, encoded as {READ, WRITE}
//   reset_value()                     : reset value of a given register index
//
// Build option: REGFILE_BYPASS_EN (used by the top, not by this package).
// -----------------------------------------------------------------------------
package regbank_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int REG_COUNT  = 32;

    localparam int                    SP_INDEX   = 29;
    localparam logic [DATA_WIDTH-1:0] SP_INIT    = 32'h03FF_FFFF;
    localparam logic [ADDR_WIDTH-1:0] ZERO_INDEX = '0;

    // Bit order matches the concatenation {READ, WRITE}.
    typedef enum logic [1:0] {
        MODE_IDLE  = 2'b00,
        MODE_WRITE = 2'b01,
        MODE_READ  = 2'b10,
        MODE_BOTH  = 2'b11
    } mode_e;

    function automatic logic [DATA_WIDTH-1:0] reset_value(input int index);
        return (index == SP_INDEX) ? SP_INIT : '0;
    endfunction

endpackage

// File: rtl/reg_bank_32x32_mux32.sv
// -----------------------------------------------------------------------------
// mux32_32
// Library 32-bit wide, 32:1 multiplexer (purely combinational).
//
// Ports:
//   data_in in   32 candidate words, data_in[k] selected when sel == k
//   sel     in   5-bit select
//   data_out out selected word
// -----------------------------------------------------------------------------
module mux32_32
    import regbank_pkg::*;
(
    input  logic [REG_COUNT-1:0][DATA_WIDTH-1:0] data_in,
    input  logic [ADDR_WIDTH-1:0]                sel,
    output logic [DATA_WIDTH-1:0]                data_out
);

    always_comb begin
        data_out = data_in[sel];
    end

endmodule

// File: rtl/reg_bank_32x32_reg32_ld.sv
// -----------------------------------------------------------------------------
// reg32_ld
// One storage register with load enable and a per-instance reset value.
//
// Ports:
//   clk     in   clock, rising edge
//   rst     in   asynchronous active-high reset, loads rst_val
//   ld      in   load enable; q <= d on the rising edge when high
//   rst_val in   value taken while rst is high (tied to a constant by the parent)
//   d       in   load data
//   q       out  stored value
// -----------------------------------------------------------------------------
module reg32_ld
    import regbank_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ld,
    input  logic [DATA_WIDTH-1:0] rst_val,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= rst_val;
        end else if (ld) begin
            q <= d;
        end
    end

endmodule

// File: rtl/reg_bank_32x32.sv
// -----------------------------------------------------------------------------
// reg_bank_32x32
// 32-entry, 32-bit register bank: two registered read ports, one write port.
// R0 reads as zero and ignores writes; R29 (stack pointer) resets to SP_INIT.
//
// Ports:
//   CLK     in   clock, all state changes on the rising edge
//   RST     in   asynchronous active-high reset
//   READ    in   read strobe  (sampled at rising edge)
//   WRITE   in   write strobe (sampled at rising edge)
//   ADDR_R1 in   read port 1 index
//   ADDR_R2 in   read port 2 index
//   ADDR_W  in   write index
//   DATA_W  in   write data
//   DATA_R1 out  registered read data, port 1
//   DATA_R2 out  registered read data, port 2
//
// Strobe semantics: no handshake and no back-pressure. Every strobe present
// at a rising edge is acted on in that edge; READ and WRITE are plain
// qualifiers with no valid/ready pairing. Outputs change only on read edges.
//
// Build option: REGFILE_BYPASS_EN
//   defined   : READ & WRITE together perform both, forwarding DATA_W to any
//               read port whose nonzero address matches ADDR_W.
//   undefined : READ & WRITE together is a no-op.
// -----------------------------------------------------------------------------
module reg_bank_32x32
    import regbank_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  READ,
    input  logic                  WRITE,
    input  logic [ADDR_WIDTH-1:0] ADDR_R1,
    input  logic [ADDR_WIDTH-1:0] ADDR_R2,
    input  logic [ADDR_WIDTH-1:0] ADDR_W,
    input  logic [DATA_WIDTH-1:0] DATA_W,
    output logic [DATA_WIDTH-1:0] DATA_R1,
    output logic [DATA_WIDTH-1:0] DATA_R2
);

    mode_e mode;
    logic  read_en;
    logic  write_en;

    logic [REG_COUNT-1:1]                 ld_en;
    logic [REG_COUNT-1:0][DATA_WIDTH-1:0] reg_q;
    logic [DATA_WIDTH-1:0]                mux_r1;
    logic [DATA_WIDTH-1:0]                mux_r2;
    logic [DATA_WIDTH-1:0]                next_r1;
    logic [DATA_WIDTH-1:0]                next_r2;

    assign mode = mode_e'({READ, WRITE});

    // Mode qualification: decides which halves of the edge are active.
    always_comb begin
        read_en  = 1'b0;
        write_en = 1'b0;
        case (mode)
            MODE_READ:  read_en  = 1'b1;
            MODE_WRITE: write_en = 1'b1;
`ifdef REGFILE_BYPASS_EN
            MODE_BOTH: begin
                read_en  = 1'b1;
                write_en = 1'b1;
            end
`else
            MODE_BOTH: begin
                read_en  = 1'b0;
                write_en = 1'b0;
            end
`endif
            default: begin
                read_en  = 1'b0;
                write_en = 1'b0;
            end
        endcase
    end

    // 5-to-32 write decoder qualified by write_en. Index 0 has no storage,
    // so its decode line does not exist and writes to R0 vanish.
    always_comb begin
        ld_en = '0;
        for (int i = 1; i < REG_COUNT; i++) begin
            ld_en[i] = write_en && (ADDR_W == ADDR_WIDTH'(i));
        end
    end

    assign reg_q[0] = '0;

    for (genvar g = 1; g < REG_COUNT; g++) begin : g_reg
        reg32_ld u_reg (
            .clk     (CLK),
            .rst     (RST),
            .ld      (ld_en[g]),
            .rst_val (reset_value(g)),
            .d       (DATA_W),
            .q       (reg_q[g])
        );
    end

    mux32_32 u_mux_r1 (
        .data_in  (reg_q),
        .sel      (ADDR_R1),
        .data_out (mux_r1)
    );

    mux32_32 u_mux_r2 (
        .data_in  (reg_q),
        .sel      (ADDR_R2),
        .data_out (mux_r2)
    );

`ifdef REGFILE_BYPASS_EN
    // Write-to-read forwarding: only a real (nonzero) write target is
    // forwarded, so a port addressing R0 still sees the mux's tied-off zero.
    always_comb begin
        next_r1 = mux_r1;
        next_r2 = mux_r2;
        if (write_en && (ADDR_W != ZERO_INDEX)) begin
            if (ADDR_R1 == ADDR_W) next_r1 = DATA_W;
            if (ADDR_R2 == ADDR_W) next_r2 = DATA_W;
        end
    end
`else
    always_comb begin
        next_r1 = mux_r1;
        next_r2 = mux_r2;
    end
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            DATA_R1 <= '0;
            DATA_R2 <= '0;
        end else if (read_en) begin
            DATA_R1 <= next_r1;
            DATA_R2 <= next_r2;
        end
    end

endmodule

// File: tb/tb_reg_bank_32x32.sv
// -----------------------------------------------------------------------------
// tb_reg_bank_32x32
// Directed bench for reg_bank_32x32 with a reference register model and an
// expected-read queue. Honours REGFILE_BYPASS_EN for the conflict case.
// -----------------------------------------------------------------------------
module tb_reg_bank_32x32;

    localparam logic [31:0] SP_INIT = 32'h03FF_FFFF;

    logic        CLK;
    logic        RST;
    logic        READ;
    logic        WRITE;
    logic [4:0]  ADDR_R1;
    logic [4:0]  ADDR_R2;
    logic [4:0]  ADDR_W;
    logic [31:0] DATA_W;
    logic [31:0] DATA_R1;
    logic [31:0] DATA_R2;

    reg_bank_32x32 dut (
        .CLK     (CLK),
        .RST     (RST),
        .READ    (READ),
        .WRITE   (WRITE),
        .ADDR_R1 (ADDR_R1),
        .ADDR_R2 (ADDR_R2),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .DATA_R1 (DATA_R1),
        .DATA_R2 (DATA_R2)
    );

    // ---------------- clock / reset ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- model and scoreboard ----------------
    logic [31:0] mem [32];
    logic [31:0] exp_q [$];
    logic [31:0] last_r1;
    logic [31:0] last_r2;
    int          n_checks;
    int          n_errors;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        mem[29] = SP_INIT;
        last_r1 = 32'h0;
        last_r2 = 32'h0;
        exp_q.delete();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // ---------------- driver ----------------
    // One clock edge with the given strobes. Model expectations are formed
    // before the edge; read results are popped and compared after it, and on
    // non-read edges the outputs are checked for holding.
    task automatic cycle(input string tag, input logic rd, input logic wr,
                         input logic [4:0] a1, input logic [4:0] a2,
                         input logic [4:0] aw, input logic [31:0] dw);
        logic did_read;
        logic [31:0] e1;
        logic [31:0] e2;
        READ = rd; WRITE = wr;
        ADDR_R1 = a1; ADDR_R2 = a2; ADDR_W = aw; DATA_W = dw;
        did_read = 1'b0;
        if (rd && !wr) begin
            exp_q.push_back(mem[a1]);
            exp_q.push_back(mem[a2]);
            did_read = 1'b1;
        end else if (wr && !rd) begin
            if (aw != 5'd0) mem[aw] = dw;
        end else if (rd && wr) begin
`ifdef REGFILE_BYPASS_EN
            exp_q.push_back((a1 == aw && aw != 5'd0) ? dw : mem[a1]);
            exp_q.push_back((a2 == aw && aw != 5'd0) ? dw : mem[a2]);
            did_read = 1'b1;
            if (aw != 5'd0) mem[aw] = dw;
`endif
        end
        @(posedge CLK);
        #1;
        READ = 1'b0; WRITE = 1'b0;
        if (did_read) begin
            if (exp_q.size() < 2) begin
                n_checks++;
                n_errors++;
                $display("FAIL %s: scoreboard queue underflow", tag);
            end else begin
                e1 = exp_q.pop_front();
                e2 = exp_q.pop_front();
                check({tag, "_r1"}, DATA_R1, e1);
                check({tag, "_r2"}, DATA_R2, e2);
                last_r1 = e1;
                last_r2 = e2;
            end
        end else begin
            check({tag, "_hold_r1"}, DATA_R1, last_r1);
            check({tag, "_hold_r2"}, DATA_R2, last_r2);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        n_checks = 0;
        n_errors = 0;
        READ = 0; WRITE = 0; ADDR_R1 = 0; ADDR_R2 = 0; ADDR_W = 0; DATA_W = 0;
        RST = 1'b1;
        model_reset();
        #12;
        RST = 1'b0;
        @(posedge CLK); #1;

        // Put nonzero data on the outputs, then reset asynchronously mid-cycle.
        cycle("pre_wr", 1'b0, 1'b1, 5'd0, 5'd0, 5'd5, 32'h0000_0055);
        cycle("pre_rd", 1'b1, 1'b0, 5'd5, 5'd29, 5'd0, 32'h0);
        #2;
        RST = 1'b1;
        #1;
        model_reset();
        check("async_rst_r1", DATA_R1, 32'h0);
        check("async_rst_r2", DATA_R2, 32'h0);
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK); #1;

        cycle("rst_rd", 1'b1, 1'b0, 5'd29, 5'd5, 5'd0, 32'h0);
        check("sp_init_const", last_r1, SP_INIT);

        cycle("wr_r7", 1'b0, 1'b1, 5'd0, 5'd0, 5'd7, 32'hDEAD_BEEF);
        cycle("rd_r7", 1'b1, 1'b0, 5'd7, 5'd7, 5'd0, 32'h0);

        cycle("wr_r0", 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 32'h1234_5678);
        cycle("rd_r0", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);

        cycle("ld_r7", 1'b1, 1'b0, 5'd7, 5'd0, 5'd0, 32'h0);
        cycle("idle",  1'b0, 1'b0, 5'd7, 5'd7, 5'd7, 32'hFFFF_FFFF);
        cycle("wr1_r7", 1'b0, 1'b1, 5'd7, 5'd7, 5'd7, 32'h0000_0001);
        cycle("rd1_r7", 1'b1, 1'b0, 5'd7, 5'd5, 5'd0, 32'h0);

        // Conflict edge: R3 preset, then READ and WRITE together.
        cycle("wr_r3", 1'b0, 1'b1, 5'd0, 5'd0, 5'd3, 32'hAAAA_0000);
        cycle("pre_cf", 1'b1, 1'b0, 5'd7, 5'd29, 5'd0, 32'h0);
        cycle("conflict", 1'b1, 1'b1, 5'd3, 5'd0, 5'd3, 32'h0000_5555);
        cycle("post_cf", 1'b1, 1'b0, 5'd3, 5'd29, 5'd0, 32'h0);

        // Random writes then read-back of both ports (including same index).
        for (int i = 0; i < 12; i++) begin
            cycle("rnd_wr", 1'b0, 1'b1, 5'd0, 5'd0,
                  5'($urandom_range(0, 31)), 32'($urandom));
        end
        for (int i = 0; i < 10; i++) begin
            logic [4:0] a;
            a = 5'($urandom_range(0, 31));
            cycle("rnd_rd", 1'b1, 1'b0, a, (i % 3 == 0) ? a : 5'($urandom_range(0, 31)),
                  5'd0, 32'h0);
        end

        // Reset pulse overlapping a write edge: the write must not commit.
        cycle("wr_r9_pre", 1'b0, 1'b1, 5'd0, 5'd0, 5'd9, 32'h0000_1111);
        READ = 1'b0; WRITE = 1'b1; ADDR_W = 5'd9; DATA_W = 32'h0000_FFFF;
        #2;
        RST = 1'b1;
        model_reset();
        @(posedge CLK); #1;
        WRITE = 1'b0;
        RST = 1'b0;
        @(negedge CLK);
        cycle("rst_wr_rd", 1'b1, 1'b0, 5'd9, 5'd29, 5'd0, 32'h0);
        check("rst_wr_r9_const", last_r1, 32'h0);

        n_checks++;
        assert (exp_q.size() == 0) else begin
            n_errors++;
            $error("FAIL queue_empty: observed=%0d expected=0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
